tetris_field_render: RTL and testbench

Pixel source for the HDMI Tetris display: walks the 640x480 raster using the read/newline/newframe strobes from the HDMI encoder and returns one 24-bit RGB pixel per read. It draws a 10x20 playfield of 16x16 px cells inside a grey border on a black background. Cell contents come from an external synchronous playfield RAM. At each cell-row boundary, the block copies the 10 cells of the next row into a local line buffer during horizontal blanking.

---
 rtl/tetris_pkg.sv | 30 +++
 rtl/tetris_field_render_if.sv | 24 ++
 rtl/tetris_palette.sv | 17 +
 rtl/tetris_field_render.sv | 183 ++++++++++++++++++
 tb/tb_tetris_field_render.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared geometry, colours and fetch-state type for the Tetris playfield renderer.
package tetris_pkg;

    localparam int CELL    = 16;
    localparam int COLS    = 10;
    localparam int ROWS    = 20;
    localparam int X0      = 240;
    localparam int Y0      = 80;
    localparam int BORDER  = 4;
    localparam int PF_W    = COLS * CELL;
    localparam int PF_H    = ROWS * CELL;
    localparam int CELL_SH = $clog2(CELL);
    // Fetch counter must also hold COLS for the final capture cycle.
    localparam int COL_W   = $clog2(COLS + 1);
    localparam int ROW_W   = $clog2(ROWS);

    localparam logic [23:0] RGB_BLACK = 24'h000000;
    localparam logic [23:0] RGB_GREY  = 24'h808080;

    localparam logic [23:0] PALETTE [8] = '{
        24'h202020, 24'h00FFFF, 24'hFFFF00, 24'h800080,
        24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFFA500
    };

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/tetris_field_render_if.sv
// Pixel strobes, pixel output and playfield-RAM port of the renderer.
interface tetris_field_render_if;

    logic        i_rd;
    logic        i_newline;
    logic        i_newframe;
    logic [23:0] o_pixel;
    logic        o_cell_rd;
    logic [7:0]  o_cell_addr;
    logic [2:0]  i_cell_data;
    logic        o_busy;

    // master: HDMI encoder plus playfield RAM; slave: the renderer.
    modport master (
        output i_rd, i_newline, i_newframe, i_cell_data,
        input  o_pixel, o_cell_rd, o_cell_addr, o_busy
    );

    modport slave (
        input  i_rd, i_newline, i_newframe, i_cell_data,
        output o_pixel, o_cell_rd, o_cell_addr, o_busy
    );

endinterface

// File: rtl/tetris_palette.sv
// Maps a cell colour index to RGB; grid-line pixels are forced black.
module tetris_palette
    import tetris_pkg::*;
(
    input  logic [2:0]  index,
    input  logic        grid,
    output logic [23:0] rgb
);

    always_comb begin
        rgb = PALETTE[index];
        if (grid) begin
            rgb = RGB_BLACK;
        end
    end

endmodule

// File: rtl/tetris_field_render.sv
// Raster walker for the Tetris playfield: classifies each pixel and refills a
// one-row line buffer from the playfield RAM at every cell-row boundary.
module tetris_field_render
    import tetris_pkg::*;
(
    input  logic                  i_pixclk,
    input  logic                  i_reset_n,
    tetris_field_render_if.slave  bus
);

    localparam logic signed [11:0] X0_S     = 12'(X0);
    localparam logic signed [11:0] Y0_S     = 12'(Y0);
    localparam logic signed [11:0] PF_W_S   = 12'(PF_W);
    localparam logic signed [11:0] PF_H_S   = 12'(PF_H);
    localparam logic signed [11:0] BORDER_S = 12'(BORDER);

    logic [9:0]          x_reg, y_reg;
    logic [9:0]          eval_x, eval_y;
    logic                pulse, load_pixel;
    logic signed [11:0]  fx, fy;
    logic                in_pf, in_border, grid;
    logic [COL_W-1:0]    col_idx;
    logic [2:0]          cell_idx;
    logic [23:0]         pf_rgb, pixel_next, pixel_reg;
    logic                trig;
    logic [ROW_W-1:0]    trig_row;

    fetch_state_t        state_reg, state_next;
    logic [COL_W-1:0]    cnt_reg, cnt_next;
    logic [7:0]          base_reg, base_next;
    logic                cell_rd, busy;
    logic [7:0]          cell_addr;
    logic                pend_reg;
    logic [COL_W-1:0]    pend_col_reg;
    logic [2:0]          linebuf_reg [COLS];
    logic [COLS-1:0]     linebuf_we;

    // Only one of rd / newline / newframe is honoured per cycle, so a single
    // classifier evaluates whichever pixel o_pixel must show next.
    always_comb begin
        pulse      = bus.i_newframe | bus.i_newline;
        load_pixel = pulse | bus.i_rd;
        eval_x     = (x_reg == 10'h3FF) ? x_reg : x_reg + 10'd1;
        eval_y     = y_reg;
        if (bus.i_newframe) begin
            eval_x = '0;
            eval_y = '0;
        end else if (bus.i_newline) begin
            eval_x = '0;
            eval_y = y_reg + 10'd1;
        end
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (pulse || bus.i_rd) begin
            x_reg <= eval_x;
            y_reg <= eval_y;
        end
    end

    always_comb begin
        fx        = signed'({2'b00, eval_x}) - X0_S;
        fy        = signed'({2'b00, eval_y}) - Y0_S;
        in_pf     = (fx >= 12'sd0) && (fx < PF_W_S) && (fy >= 12'sd0) && (fy < PF_H_S);
        in_border = (fx >= -BORDER_S) && (fx < PF_W_S + BORDER_S) &&
                    (fy >= -BORDER_S) && (fy < PF_H_S + BORDER_S);
        grid      = (&fx[CELL_SH-1:0]) | (&fy[CELL_SH-1:0]);
        col_idx   = COL_W'(fx[11:CELL_SH]);
        cell_idx  = '0;
        if (in_pf) begin
            cell_idx = linebuf_reg[col_idx];
        end
        trig      = pulse && (fy >= 12'sd0) && (fy < PF_H_S) && (fy[CELL_SH-1:0] == '0);
        trig_row  = ROW_W'(fy[11:CELL_SH]);
    end

    tetris_palette u_palette (
        .index (cell_idx),
        .grid  (grid),
        .rgb   (pf_rgb)
    );

    always_comb begin
        pixel_next = RGB_BLACK;
        if (in_pf) begin
            pixel_next = pf_rgb;
        end else if (in_border) begin
            pixel_next = RGB_GREY;
        end
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pixel_reg <= '0;
        end else if (load_pixel) begin
            pixel_reg <= pixel_next;
        end
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= FETCH_IDLE;
            cnt_reg   <= '0;
            base_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            base_reg  <= base_next;
        end
    end

    // FETCH spans COLS read cycles plus one more to capture the last word.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        base_next  = base_reg;
        cell_rd    = 1'b0;
        cell_addr  = '0;
        busy       = 1'b0;
        case (state_reg)
            FETCH_IDLE: state_next = FETCH_IDLE;
            FETCH_RUN: begin
                busy = 1'b1;
                if (cnt_reg < COL_W'(COLS)) begin
                    cell_rd   = 1'b1;
                    cell_addr = base_reg + 8'(cnt_reg);
                end
                if (cnt_reg == COL_W'(COLS)) begin
                    state_next = FETCH_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + COL_W'(1);
                end
            end
            default: state_next = FETCH_IDLE;
        endcase
        if (trig) begin
            state_next = FETCH_RUN;
            cnt_next   = '0;
            base_next  = 8'(trig_row * COLS);
        end
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pend_reg     <= 1'b0;
            pend_col_reg <= '0;
        end else begin
            pend_reg     <= cell_rd;
            pend_col_reg <= cnt_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_linebuf_we
            assign linebuf_we[gi] = pend_reg && (pend_col_reg == COL_W'(gi));
        end
    endgenerate

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < COLS; i++) begin
                linebuf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < COLS; i++) begin
                if (linebuf_we[i]) begin
                    linebuf_reg[i] <= bus.i_cell_data;
                end
            end
        end
    end

    assign bus.o_pixel     = pixel_reg;
    assign bus.o_cell_rd   = cell_rd;
    assign bus.o_cell_addr = cell_addr;
    assign bus.o_busy      = busy;

endmodule

// File: tb/tb_tetris_field_render.sv
// Directed bench for tetris_field_render with a synchronous playfield RAM model.
module tb_tetris_field_render;

    logic clk;
    logic rst_n;
    logic [2:0] ram [200];
    int x_tb;
    int checks;
    int errors;

    tetris_field_render_if bus ();

    tetris_field_render dut (
        .i_pixclk  (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.o_cell_rd) begin
            bus.i_cell_data <= ram[bus.o_cell_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_to(input int xt);
        while (x_tb < xt) begin
            bus.i_rd = 1'b1;
            tick();
            x_tb++;
        end
        bus.i_rd = 1'b0;
    endtask

    task automatic newline();
        bus.i_newline = 1'b1;
        tick();
        bus.i_newline = 1'b0;
        x_tb = 0;
    endtask

    task automatic newframe();
        bus.i_newframe = 1'b1;
        tick();
        bus.i_newframe = 1'b0;
        x_tb = 0;
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            newline();
        end
    endtask

    task automatic pix(input string tag, input int xt, input logic [23:0] exp);
        rd_to(xt);
        check(tag, 32'(bus.o_pixel), 32'(exp));
    endtask

    // Entered one cycle after the trigger pulse; covers fetch cycles 1..12.
    task automatic check_fetch(input string tag, input int base);
        for (int c = 1; c <= 12; c++) begin
            check($sformatf("%s busy c%0d", tag, c), 32'(bus.o_busy), (c <= 11) ? 32'd1 : 32'd0);
            check($sformatf("%s rd c%0d", tag, c), 32'(bus.o_cell_rd), (c <= 10) ? 32'd1 : 32'd0);
            if (c <= 10) begin
                check($sformatf("%s addr c%0d", tag, c), 32'(bus.o_cell_addr), 32'(base + c - 1));
            end
            tick();
        end
    endtask

    task automatic check_quiet(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            check($sformatf("%s busy c%0d", tag, c), 32'({bus.o_busy, bus.o_cell_rd}), 32'd0);
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        x_tb = 0;
        rst_n = 1'b0;
        bus.i_rd = 1'b0;
        bus.i_newline = 1'b0;
        bus.i_newframe = 1'b0;
        for (int i = 0; i < 200; i++) ram[i] = 3'd0;

        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("reset pixel", 32'(bus.o_pixel), 32'h000000);
        check("reset cell_rd", 32'(bus.o_cell_rd), 32'd0);
        check("reset busy", 32'(bus.o_busy), 32'd0);
        check("reset addr", 32'(bus.o_cell_addr), 32'd0);

        // Border rows and an all-empty playfield row.
        newframe();
        lines(76);
        pix("y76 x235 black", 235, 24'h000000);
        pix("y76 x236 grey", 236, 24'h808080);
        pix("y76 x239 grey", 239, 24'h808080);
        pix("y76 x240 grey", 240, 24'h808080);
        lines(4);
        pix("y80 x236 grey", 236, 24'h808080);
        pix("y80 x240 empty", 240, 24'h202020);
        pix("y80 x255 grid", 255, 24'h000000);
        pix("y80 x256 empty", 256, 24'h202020);

        // Row 0 loaded with every palette entry.
        ram[0] = 3'd1; ram[1] = 3'd2; ram[2] = 3'd3; ram[3] = 3'd4; ram[4] = 3'd5;
        ram[5] = 3'd6; ram[6] = 3'd7; ram[7] = 3'd1; ram[8] = 3'd2; ram[9] = 3'd3;
        newframe();
        lines(79);
        newline();
        check_fetch("row0", 0);
        pix("y80 x240 c1", 240, 24'h00FFFF);
        pix("y80 x256 c2", 256, 24'hFFFF00);
        pix("y80 x272 c3", 272, 24'h800080);
        pix("y80 x288 c4", 288, 24'h00FF00);
        pix("y80 x304 c5", 304, 24'hFF0000);
        pix("y80 x320 c6", 320, 24'h0000FF);
        pix("y80 x338 c7", 338, 24'hFFA500);
        pix("y80 x351 grid", 351, 24'h000000);
        pix("y80 x352 c1", 352, 24'h00FFFF);
        pix("y80 x398 c3", 398, 24'h800080);
        pix("y80 x399 grid", 399, 24'h000000);
        pix("y80 x400 grey", 400, 24'h808080);
        pix("y80 x403 grey", 403, 24'h808080);
        pix("y80 x404 black", 404, 24'h000000);

        // Off-boundary lines keep the buffer; row 1 fetched at y=96.
        for (int i = 10; i < 20; i++) ram[i] = 3'd5;
        newline();
        check_quiet("y81", 12);
        pix("y81 x240 kept", 240, 24'h00FFFF);
        lines(14);
        pix("y95 x240 hgrid", 240, 24'h000000);
        pix("y95 x256 hgrid", 256, 24'h000000);
        newline();
        check_fetch("row1", 10);
        pix("y96 x240 c5", 240, 24'hFF0000);
        ram[11] = 3'd6;
        newline();
        check_quiet("y97", 12);
        pix("y97 x256 kept", 256, 24'hFF0000);

        // Simultaneous newframe and newline: frame restart wins.
        bus.i_newframe = 1'b1;
        bus.i_newline = 1'b1;
        tick();
        bus.i_newframe = 1'b0;
        bus.i_newline = 1'b0;
        x_tb = 0;
        check("dual pulse pixel", 32'(bus.o_pixel), 32'h000000);
        check_quiet("dual", 3);
        lines(79);
        newline();
        check_fetch("dual row0", 0);
        pix("dual y80 x240", 240, 24'h00FFFF);

        // Reset during the fifth fetch cycle.
        newframe();
        lines(79);
        newline();
        for (int c = 1; c < 5; c++) tick();
        check("pre-reset busy", 32'(bus.o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async busy", 32'(bus.o_busy), 32'd0);
        check("async cell_rd", 32'(bus.o_cell_rd), 32'd0);
        check("async pixel", 32'(bus.o_pixel), 32'h000000);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) ram[i] = 3'd0;
        tick();
        newframe();
        lines(80);
        pix("post-reset y80 x240", 240, 24'h202020);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
